sized_byte_memory: RTL and testbench

Parametrised, byte-addressed, little-endian data memory for the CPU. It accepts one load or store per cycle over a valid/ready request port and returns an in-order response after a fixed, configurable latency. It supports access sizes of 1, 2, 4 and 8 bytes, sign or zero extension on loads, unaligned accesses with address wrap-around, and optional alignment checking. It sits between the CPU datapath (load/store unit) and on-chip RAM, and replaces the fixed 64-bit doubleword-only memory.

---
 rtl/sized_byte_memory.sv | 141 ++++++++++++++
 tb/tb_sized_byte_memory.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sized_byte_memory.sv
// Byte-addressed little-endian data memory built from BYTES interleaved byte banks.
// Sized loads/stores with address wrap-around and fixed-latency, in-order responses.
module sized_byte_memory #(
   parameter int unsigned BYTES        = 8,
   parameter int unsigned ADDR_BITS    = 16,
   parameter int unsigned READ_LATENCY = 1,
   parameter bit          ALIGN_CHECK  = 1'b0
) (
   input  logic                 Clk,
   input  logic                 Reset_n,
   input  logic                 Req_valid,
   output logic                 Req_ready,
   input  logic                 Req_write,
   input  logic [1:0]           Req_size,
   input  logic                 Req_unsigned,
   input  logic [63:0]          Req_addr,
   input  logic [8*BYTES-1:0]   Req_wdata,
   output logic                 Rsp_valid,
   output logic [8*BYTES-1:0]   Rsp_data,
   output logic                 Rsp_err
);
   localparam int unsigned DATA_W = 8 * BYTES;
   localparam int unsigned OFFS   = $clog2(BYTES);
   localparam int unsigned ROT_W  = (OFFS == 0) ? 1 : OFFS;
   localparam int unsigned ROW_W  = ADDR_BITS - OFFS;
   localparam int unsigned DEPTH  = 1 << ROW_W;
   localparam int unsigned LAST   = READ_LATENCY - 1;

   logic [ADDR_BITS-1:0] addr;
   logic [3:0]           nBytes;
   logic                 accept;
   logic                 reqErr;
   logic                 doStore;
   logic [ROT_W-1:0]     reqRot;
   logic [ROT_W-1:0]     bankLane  [BYTES];
   logic [ADDR_BITS-1:0] bankAddr  [BYTES];
   logic [ROW_W-1:0]     bankRow   [BYTES];
   logic [BYTES-1:0]     bankWe;
   logic [7:0]           bankWdata [BYTES];

   logic unusedAddrBits;
   assign unusedAddrBits = ^Req_addr[63:ADDR_BITS];

   // Request decode: each bank works out which lane it serves and which row that lane hits.
   always_comb begin
      addr    = Req_addr[ADDR_BITS-1:0];
      nBytes  = 4'(1) << Req_size;
      accept  = Req_valid & Req_ready & Reset_n;
      reqErr  = (32'(nBytes) > BYTES) ||
                (ALIGN_CHECK && ((addr & ADDR_BITS'(nBytes - 4'd1)) != '0));
      doStore = accept & Req_write & ~reqErr;
      reqRot  = ROT_W'(addr & ADDR_BITS'(BYTES - 1));
      for (int b = 0; b < BYTES; b++) begin
         bankLane[b]  = ROT_W'(b) - reqRot;
         bankAddr[b]  = addr + ADDR_BITS'(bankLane[b]);
         bankRow[b]   = bankAddr[b][ADDR_BITS-1:OFFS];
         bankWe[b]    = doStore && (32'(bankLane[b]) < 32'(nBytes));
         bankWdata[b] = Req_wdata[8*bankLane[b] +: 8];
      end
   end

   logic [7:0]        mem     [BYTES][DEPTH];
   logic [DATA_W-1:0] stBytes [READ_LATENCY];

   // Banks read on the accepting edge, so a load sees every store accepted before it.
   always_ff @(posedge Clk) begin
      for (int b = 0; b < BYTES; b++) begin
         if (bankWe[b]) begin
            mem[b][bankRow[b]] <= bankWdata[b];
         end
         stBytes[0][8*b +: 8] <= mem[b][bankRow[b]];
      end
      for (int i = 1; i < READ_LATENCY; i++) begin
         stBytes[i] <= stBytes[i-1];
      end
   end

   logic [READ_LATENCY-1:0] stValid;
   logic [READ_LATENCY-1:0] stErr;
   logic [READ_LATENCY-1:0] stWrite;
   logic [READ_LATENCY-1:0] stUns;
   logic [1:0]              stSize [READ_LATENCY];
   logic [ROT_W-1:0]        stRot  [READ_LATENCY];

   logic [3:0]        lastN;
   logic              signBit;
   logic [ROT_W-1:0]  laneBank [BYTES];
   logic [DATA_W-1:0] loadData;

   // Final stage: un-rotate bank bytes into lanes, then sign/zero-extend above the access size.
   always_comb begin
      lastN    = 4'(1) << stSize[LAST];
      signBit  = 1'b0;
      loadData = '0;
      for (int k = 0; k < BYTES; k++) begin
         laneBank[k]           = ROT_W'(ROT_W'(k) + stRot[LAST]);
         loadData[8*k +: 8]    = stBytes[LAST][8*laneBank[k] +: 8];
         if (32'(k) + 32'd1 == 32'(lastN)) begin
            signBit = loadData[8*k + 7];
         end
      end
      for (int k = 0; k < BYTES; k++) begin
         if (32'(k) >= 32'(lastN)) begin
            loadData[8*k +: 8] = {8{signBit & ~stUns[LAST]}};
         end
      end
      if (!stValid[LAST] || stErr[LAST] || stWrite[LAST]) begin
         loadData = '0;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         Req_ready <= 1'b0;
         stValid   <= '0;
         Rsp_valid <= 1'b0;
         Rsp_err   <= 1'b0;
         Rsp_data  <= '0;
      end else begin
         Req_ready  <= 1'b1;
         stValid[0] <= accept;
         stErr[0]   <= reqErr;
         stWrite[0] <= Req_write;
         stUns[0]   <= Req_unsigned;
         stSize[0]  <= Req_size;
         stRot[0]   <= reqRot;
         for (int i = 1; i < READ_LATENCY; i++) begin
            stValid[i] <= stValid[i-1];
            stErr[i]   <= stErr[i-1];
            stWrite[i] <= stWrite[i-1];
            stUns[i]   <= stUns[i-1];
            stSize[i]  <= stSize[i-1];
            stRot[i]   <= stRot[i-1];
         end
         Rsp_valid <= stValid[LAST];
         Rsp_err   <= stValid[LAST] & stErr[LAST];
         Rsp_data  <= loadData;
      end
   end

endmodule

// File: tb/tb_sized_byte_memory.sv
// Two configurations of sized_byte_memory driven with shared stimulus and checked
// every cycle against a byte-array reference model.
module tb_sized_byte_memory;
   localparam int unsigned LAT_A = 2;
   localparam int unsigned LAT_B = 1;

   logic        clk = 1'b0;
   logic        resetN;
   logic        reqValid, reqWrite, reqUnsigned;
   logic [1:0]  reqSize;
   logic [63:0] reqAddr, reqWdata;
   logic        readyA, validA, errA;
   logic [63:0] dataA;
   logic        readyB, validB, errB;
   logic [31:0] dataB;

   always #5 clk = ~clk;

   sized_byte_memory #(.BYTES(8), .ADDR_BITS(16), .READ_LATENCY(LAT_A), .ALIGN_CHECK(1'b0)) dutA (
      .Clk(clk), .Reset_n(resetN), .Req_valid(reqValid), .Req_ready(readyA),
      .Req_write(reqWrite), .Req_size(reqSize), .Req_unsigned(reqUnsigned),
      .Req_addr(reqAddr), .Req_wdata(reqWdata),
      .Rsp_valid(validA), .Rsp_data(dataA), .Rsp_err(errA));

   sized_byte_memory #(.BYTES(4), .ADDR_BITS(12), .READ_LATENCY(LAT_B), .ALIGN_CHECK(1'b1)) dutB (
      .Clk(clk), .Reset_n(resetN), .Req_valid(reqValid), .Req_ready(readyB),
      .Req_write(reqWrite), .Req_size(reqSize), .Req_unsigned(reqUnsigned),
      .Req_addr(reqAddr), .Req_wdata(reqWdata[31:0]),
      .Rsp_valid(validB), .Rsp_data(dataB), .Rsp_err(errB));

   typedef struct {
      int unsigned due;
      logic        err;
      logic [63:0] data;
   } rsp_t;

   rsp_t        qA[$], qB[$];
   rsp_t        lastA, lastB;
   logic [7:0]  mem [2][65536];
   int unsigned cyc = 0;
   int          checks = 0;
   int          fails = 0;
   bit          readyExp = 1'b0;
   bit          checking = 1'b0;
   bit          expVA, expVB;

   function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   // Reference: the memory is a flat byte array; an access touches bytes (A+k) mod capacity.
   function automatic rsp_t model(input int id, input int unsigned bytes,
                                  input int unsigned abits, input bit align);
      rsp_t r;
      int unsigned n, cap, a;
      n = 1 << reqSize;
      cap = 1 << abits;
      a = 32'(reqAddr[15:0]) % cap;
      r.due = 0;
      r.data = '0;
      r.err = (n > bytes) || (align && (a % n) != 0);
      if (!r.err) begin
         if (reqWrite) begin
            for (int k = 0; k < n; k++) mem[id][(a + k) % cap] = reqWdata[8*k +: 8];
         end else begin
            for (int k = 0; k < n; k++) r.data[8*k +: 8] = mem[id][(a + k) % cap];
            if (!reqUnsigned && r.data[8*n-1]) begin
               for (int i = 8*n; i < 8*bytes; i++) r.data[i] = 1'b1;
            end
         end
      end
      return r;
   endfunction

   task automatic tick();
      @(posedge clk);
      cyc++;
      if (!resetN) begin
         readyExp = 1'b0;
         qA.delete();
         qB.delete();
      end else begin
         if (reqValid && readyExp) begin
            lastA = model(0, 8, 16, 1'b0);
            lastA.due = cyc + LAT_A;
            qA.push_back(lastA);
            lastB = model(1, 4, 12, 1'b1);
            lastB.due = cyc + LAT_B;
            qB.push_back(lastB);
         end
         readyExp = 1'b1;
      end
      #1;
   endtask

   task automatic doReq(input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [15:0] a, input logic [63:0] wd);
      int guard = 0;
      while (!readyExp && guard < 8) begin
         tick();
         guard++;
      end
      if (!readyExp) check("ready wait timeout", 64'(readyA), 64'd1);
      reqValid    = 1'b1;
      reqWrite    = wr;
      reqSize     = sz;
      reqUnsigned = uns;
      reqAddr     = {16'($urandom), 32'($urandom), a};
      reqWdata    = wd;
      tick();
      reqValid    = 1'b0;
   endtask

   always @(negedge clk) begin
      if (checking) begin
         check("ready A", 64'(readyA), 64'(readyExp));
         check("ready B", 64'(readyB), 64'(readyExp));
         expVA = (qA.size() != 0) && (qA[0].due == cyc);
         check("rsp valid A", 64'(validA), 64'(expVA));
         if (expVA) begin
            if (validA) begin
               check("rsp err A", 64'(errA), 64'(qA[0].err));
               check("rsp data A", dataA, qA[0].data);
            end
            void'(qA.pop_front());
         end
         expVB = (qB.size() != 0) && (qB[0].due == cyc);
         check("rsp valid B", 64'(validB), 64'(expVB));
         if (expVB) begin
            if (validB) begin
               check("rsp err B", 64'(errB), 64'(qB[0].err));
               check("rsp data B", 64'(dataB), qB[0].data);
            end
            void'(qB.pop_front());
         end
      end
   end

   initial begin
      logic [15:0] bases [3];
      bases[0] = 16'h0000;
      bases[1] = 16'h0100;
      bases[2] = 16'hFFC0;
      resetN = 1'b0;
      reqValid = 1'b0; reqWrite = 1'b0; reqSize = 2'd0; reqUnsigned = 1'b0;
      reqAddr = '0; reqWdata = '0;

      // Reset held for three edges, with a request presented that must be ignored
      tick();
      checking = 1'b1;
      reqValid = 1'b1;
      tick();
      tick();
      reqValid = 1'b0;
      resetN = 1'b1;
      check("t1 ready first cycle after release", 64'(readyA), 64'd0);
      tick();
      check("t1 ready second cycle after release", 64'(readyA), 64'd1);

      // Fill the address windows used below so no load reads uninitialised bytes
      for (int w = 0; w < 3; w++) begin
         for (int i = 0; i < ((w == 2) ? 16 : 20); i++) begin
            doReq(1'b1, 2'd2, 1'b0, bases[w] + 16'(4*i), {$urandom, $urandom});
         end
      end

      doReq(1'b1, 2'd3, 1'b0, 16'h0100, 64'h1122334455667788);
      check("t2 store data", lastA.data, 64'd0);
      doReq(1'b0, 2'd3, 1'b0, 16'h0100, '0);
      check("t2 double load", lastA.data, 64'h1122334455667788);
      check("t2 double load err", 64'(lastA.err), 64'd0);
      check("t6 double load size err B", 64'(lastB.err), 64'd1);

      doReq(1'b1, 2'd0, 1'b0, 16'h0103, 64'h80);
      doReq(1'b0, 2'd0, 1'b0, 16'h0103, '0);
      check("t3 signed byte", lastA.data, 64'hFFFFFFFFFFFFFF80);
      check("t3 signed byte B", lastB.data, 64'h00000000FFFFFF80);
      doReq(1'b0, 2'd0, 1'b1, 16'h0103, '0);
      check("t3 unsigned byte", lastA.data, 64'h80);
      doReq(1'b0, 2'd1, 1'b1, 16'h0102, '0);
      check("t3 unsigned half", lastA.data, 64'h8066);

      doReq(1'b1, 2'd3, 1'b0, 16'hFFFC, 64'hA1A2A3A4A5A6A7A8);
      doReq(1'b0, 2'd2, 1'b1, 16'h0000, '0);
      check("t4 wrapped word low", lastA.data, 64'hA1A2A3A4);
      doReq(1'b0, 2'd2, 1'b1, 16'hFFFC, '0);
      check("t4 word at top", lastA.data, 64'hA5A6A7A8);
      doReq(1'b0, 2'd2, 1'b1, 16'hFFFE, '0);
      check("t4 straddling word", lastA.data, 64'hA3A4A5A6);
      check("t4 straddling word align err B", 64'(lastB.err), 64'd1);

      doReq(1'b1, 2'd2, 1'b0, 16'h0100, 64'hCAFEF00D);
      doReq(1'b0, 2'd2, 1'b1, 16'h0102, '0);
      check("t5 misaligned word A", lastA.data, 64'h3344CAFE);
      check("t5 misaligned word err B", 64'(lastB.err), 64'd1);
      check("t5 misaligned word data B", lastB.data, 64'd0);
      doReq(1'b1, 2'd1, 1'b0, 16'h0101, 64'hBEEF);
      doReq(1'b0, 2'd0, 1'b1, 16'h0101, '0);
      check("t5 byte after half store A", lastA.data, 64'hEF);
      check("t5 byte after rejected store B", lastB.data, 64'hF0);

      // Reset with a load in flight: its response must never appear
      doReq(1'b0, 2'd2, 1'b1, 16'h0100, '0);
      resetN = 1'b0;
      reqValid = 1'b1;
      tick();
      tick();
      reqValid = 1'b0;
      resetN = 1'b1;
      doReq(1'b0, 2'd2, 1'b1, 16'h0100, '0);
      check("t6 load after reset A", lastA.data, 64'hCABEEF0D);
      check("t6 load after reset B", lastB.data, 64'hCAFEF00D);

      repeat (2000) begin
         if ($urandom_range(0, 299) == 0) begin
            resetN = 1'b0;
            reqValid = 1'b1;
            tick();
            tick();
            resetN = 1'b1;
         end
         reqValid    = ($urandom_range(0, 3) != 0);
         reqWrite    = ($urandom_range(0, 2) == 0);
         reqSize     = 2'($urandom_range(0, 3));
         reqUnsigned = 1'($urandom);
         reqAddr     = {16'($urandom), 32'($urandom),
                        bases[$urandom_range(0, 2)] + 16'($urandom_range(0, 63))};
         reqWdata    = {$urandom, $urandom};
         tick();
      end

      reqValid = 1'b0;
      repeat (LAT_A + 3) tick();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
